alu_op_sequencer: RTL

Multi-cycle controller that sequences the 32-bit integer ALU for one requester at a time. It accepts an opcode and two operands over a valid/ready handshake and drives registered A/B/opcode into the ALU. It waits an opcode-dependent number of cycles, captures the 64-bit ALU result into HI/LO, and returns it over a valid/ready response handshake. It sits between the control unit and the ALU and owns the ALU inputs exclusively.

---
 rtl/alu_op_sequencer_if.sv | 32 +++
 rtl/alu_op_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Handshake and ALU bus bundle for alu_op_sequencer: the slave modport is the
// sequencer side, and the master modport is the requester/ALU/consumer side.
interface alu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_c;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic        rsp_hi_we;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_c, rsp_ready,
    output req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_lo, rsp_hi,
           rsp_hi_we, rsp_err, busy
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_c, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_lo, rsp_hi,
           rsp_hi_we, rsp_err, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU sequencer: accepts one operation, waits out the ALU latency, and returns HI/LO.
// Optional macro DIV_ZERO_CHK_EN rejects DIV with B=0 directly in IDLE.
module alu_op_sequencer #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input logic            clk,
  input logic            clear,
  alu_op_sequencer_if.slave bus
);
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, CAPTURE, RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        busy_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [4:0]  alu_opcode_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_lo_q;
  logic [31:0] rsp_hi_q;
  logic        rsp_hi_we_q;
  logic        rsp_err_q;
  logic        reject_d;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_MUL, OP_DIV, OP_NEG, OP_NOT: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] op_wait(input logic [4:0] op);
    case (op)
      OP_MUL:  op_wait = 4'(MUL_LAT - 1);
      OP_DIV:  op_wait = 4'(DIV_LAT - 1);
      default: op_wait = 4'(ALU_LAT - 1);
    endcase
  endfunction

  // Requests that bypass the ALU entirely and answer with an error response.
  always_comb begin
    reject_d = !op_legal(bus.req_opcode);
`ifdef DIV_ZERO_CHK_EN
    if (bus.req_opcode == OP_DIV && bus.req_b == '0) reject_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_lo_q     <= '0;
      rsp_hi_q     <= '0;
      rsp_hi_we_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (reject_d) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_lo_q    <= '0;
              rsp_hi_q    <= '0;
              rsp_hi_we_q <= 1'b0;
            end else begin
              state_q      <= LOAD;
              alu_a_q      <= bus.req_a;
              alu_b_q      <= bus.req_b;
              alu_opcode_q <= bus.req_opcode;
            end
          end
        end
        LOAD: begin
          cnt_q   <= op_wait(alu_opcode_q);
          state_q <= EXEC;
        end
        EXEC: begin
          if (cnt_q == '0) state_q <= CAPTURE;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        CAPTURE: begin
          rsp_lo_q    <= bus.alu_c[31:0];
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
          if (alu_opcode_q == OP_MUL || alu_opcode_q == OP_DIV) begin
            rsp_hi_q    <= bus.alu_c[63:32];
            rsp_hi_we_q <= 1'b1;
          end else begin
            rsp_hi_q    <= '0;
            rsp_hi_we_q <= 1'b0;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.busy       = busy_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_lo     = rsp_lo_q;
  assign bus.rsp_hi     = rsp_hi_q;
  assign bus.rsp_hi_we  = rsp_hi_we_q;
  assign bus.rsp_err    = rsp_err_q;
endmodule
